keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Multiplexed input-side counterpart of the 4-digit muxed seven-segment driver.
- Scans a 4x4 matrix keypad by driving one row low at a time and reading four pulled-up column lines.
- Debounces the pressed key and presents a 4-bit key code with a one-cycle valid strobe.
- Output feeds the digit registers that drive the display (i_v0..i_v3 of the display block).

Parameters:
- SCAN_DIV_W, 12: prescaler width; one scan tick every 2^SCAN_DIV_W clk cycles.
- DEBOUNCE_CNT, 4: number of consecutive agreeing scan-tick samples required to accept a press or a release; legal range 2..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- i_col  input  4  column lines, active-low, asynchronous to clk; 4'b1111 = no key.
- o_row  output  4  row drive, active-low one-hot; exactly one bit low at all times.
- o_key  output  4  accepted key code = row*4 + col; holds last accepted value.
- o_valid  output  1  one-cycle pulse when a new press is accepted.
- o_pressed  output  1  level; high from acceptance until debounced release.

Behaviour:
- i_col passes through a 2-flop synchronizer before any use. Synchronizer resets to 4'b1111.
- Prescaler r_div, SCAN_DIV_W bits, is free-running. A tick occurs in the cycle where r_div is all ones.
- Sampling happens only on a tick, so the row is settled for the whole scan period.
- Row index r_row, 2 bits. o_row = ~(4'b0001 << r_row), registered. "Advance row" means r_row+1, wrapping from 3 to 0, applied on the tick edge.
- Column decode of the synchronized sample:
  - exactly one bit low: col = index of that bit, valid single.
  - 4'b1111: idle.
  - two or more bits low: ghost; treated as idle.
- State machine, 4 states. All transitions are evaluated only on a tick; between ticks the state holds.
  - SCAN
    - single: latch cand = {r_row, col}; cnt <= 1; go to DEBOUNCE; row frozen.
    - otherwise: advance row.
  - DEBOUNCE
    - single with the same col: cnt+1.
    - If cnt+1 == DEBOUNCE_CNT: o_key <= cand, o_valid <= 1 for one cycle, o_pressed <= 1, cnt <= 0, go to HELD.
    - any other sample: cnt <= 0; go to SCAN; advance row; no output change.
  - HELD
    - sample is idle: cnt <= 1; go to RELEASE.
    - otherwise: stay. Row stays frozen.
  - RELEASE
    - idle: cnt+1. If cnt+1 == DEBOUNCE_CNT: o_pressed <= 0, cnt <= 0, go to SCAN, advance row.
    - not idle: cnt <= 0; back to HELD. No new o_valid is issued.
- Latency: o_valid rises one clk after the tick carrying the DEBOUNCE_CNT-th agreeing sample, counting the detecting tick as sample 1.
- o_valid never exceeds one cycle and occurs at most once per press.
- cnt width is 4 bits and must not overflow.
- Reset values: r_div = 0, r_row = 0, o_row = 4'b1110, o_key = 0, o_valid = 0, o_pressed = 0, state SCAN, cnt = 0, cand = 0.
- Reset mid-operation: all state is dropped immediately; scanning restarts at row 0 with no pending press.

Decomposition:
- Package keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - NUM_ROWS = 4, NUM_COLS = 4, KEY_W = 4;
  - IDLE_COLS = 4'b1111.
- Sub-module sync_2ff, parameterized width, reset value all-ones: the column synchronizer.

Test Plan (SCAN_DIV_W = 4, so one tick every 16 cycles; DEBOUNCE_CNT = 4):
- Reset: assert rst with i_col = 4'b1111 -> o_row = 4'b1110, o_key = 0, o_valid = 0, o_pressed = 0. After release, o_row cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110 with a 16-cycle period.
- Key press: model key at row 2, col 1; i_col[1] is low only while o_row[2] is low, held stable -> exactly one o_valid pulse, o_key = 9, o_pressed = 1. o_row frozen at 4'b1011 while the key is held.
- Bounce: key 9 low for 2 ticks, then released -> no o_valid; o_key unchanged; scan resumes with 4'b0111.
- Ghost: i_col = 4'b1100 on row 0 -> no o_valid; row keeps advancing.
- Release with glitch: hold key 9, release, re-press for 1 tick, then release -> o_pressed stays 1 across the glitch and falls 4 idle ticks after the final release; no second o_valid.
- Reset mid-DEBOUNCE: press key 0 and assert rst after 2 ticks -> all outputs take reset values; no o_valid until a fresh, fully debounced press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   localparam logic [NUM_COLS-1:0] IDLE_COLS = 4'b1111;

   typedef struct packed {
      logic       single;
      logic [1:0] col;
   } col_dec_t;

   // Only a lone low column is a usable key; idle and ghosted patterns alike report no key.
   function automatic col_dec_t col_decode(input logic [NUM_COLS-1:0] c);
      col_dec_t d;
      d = '0;
      case (c)
         4'b1110: begin d.single = 1'b1; d.col = 2'd0; end
         4'b1101: begin d.single = 1'b1; d.col = 2'd1; end
         4'b1011: begin d.single = 1'b1; d.col = 2'd2; end
         4'b0111: begin d.single = 1'b1; d.col = 2'd3; end
         default: d = '0;
      endcase
      return d;
   endfunction
endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the asynchronous column lines; resets to all ones (no key).
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   // Two-stage capture of the raw lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row-strobed scan, debounced press/release, key code with valid strobe.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_W   = 12,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_col,
   output logic [3:0] o_row,
   output logic [3:0] o_key,
   output logic       o_valid,
   output logic       o_pressed
);
   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CNT);

   logic [NUM_COLS-1:0]   col_s;
   logic [SCAN_DIV_W-1:0] r_div;
   logic                  tick;
   col_dec_t              dec;

   state_t           state, state_nx;
   logic [3:0]       cnt, cnt_nx, cnt_inc;
   logic [KEY_W-1:0] cand, cand_nx, key_nx;
   logic [1:0]       r_row, row_nx;
   logic             valid_nx, pressed_nx;

   sync_2ff #(.WIDTH(NUM_COLS)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (i_col),
      .q   (col_s)
   );

   assign tick    = &r_div;
   assign dec     = col_decode(col_s);
   assign cnt_inc = cnt + 4'd1;

   // Free-running prescaler; a tick each time it wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_div <= '0;
      else     r_div <= r_div + 1'b1;
   end

   // State, counters, row drive and outputs register the next-state values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         cnt       <= '0;
         cand      <= '0;
         r_row     <= '0;
         o_row     <= 4'b1110;
         o_key     <= '0;
         o_valid   <= 1'b0;
         o_pressed <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         cand      <= cand_nx;
         r_row     <= row_nx;
         o_row     <= ~(4'b0001 << row_nx);
         o_key     <= key_nx;
         o_valid   <= valid_nx;
         o_pressed <= pressed_nx;
      end
   end

   // Scan/debounce decisions, evaluated only on a tick; the row stays frozen while a key is tracked
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      cand_nx    = cand;
      row_nx     = r_row;
      key_nx     = o_key;
      valid_nx   = 1'b0;
      pressed_nx = o_pressed;
      if (tick) begin
         case (state)
            SCAN: begin
               if (dec.single) begin
                  cand_nx  = {r_row, dec.col};
                  cnt_nx   = 4'd1;
                  state_nx = DEBOUNCE;
               end else begin
                  row_nx = r_row + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (dec.single && dec.col == cand[1:0]) begin
                  if (cnt_inc == DB_LAST) begin
                     key_nx     = cand;
                     valid_nx   = 1'b1;
                     pressed_nx = 1'b1;
                     cnt_nx     = '0;
                     state_nx   = HELD;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  cnt_nx   = '0;
                  state_nx = SCAN;
                  row_nx   = r_row + 2'd1;
               end
            end
            HELD: begin
               if (!dec.single) begin
                  cnt_nx   = 4'd1;
                  state_nx = RELEASE;
               end
            end
            RELEASE: begin
               if (!dec.single) begin
                  if (cnt_inc == DB_LAST) begin
                     pressed_nx = 1'b0;
                     cnt_nx     = '0;
                     state_nx   = SCAN;
                     row_nx     = r_row + 2'd1;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  cnt_nx   = '0;
                  state_nx = HELD;
               end
            end
            default: state_nx = SCAN;
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 16-cycle scan tick, 4-sample debounce, modelled key matrix.
module tb_keypad_scanner;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] i_col;
   logic [3:0] o_row, o_key;
   logic       o_valid, o_pressed;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;

   logic key9 = 1'b0;   // row 2, col 1
   logic key0 = 1'b0;   // row 0, col 0
   logic ghost = 1'b0;  // cols 0 and 1 together on row 0

   keypad_scanner #(.SCAN_DIV_W(4), .DEBOUNCE_CNT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_col     (i_col),
      .o_row     (o_row),
      .o_key     (o_key),
      .o_valid   (o_valid),
      .o_pressed (o_pressed)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its column low only while its row is driven low
   always_comb begin
      i_col = 4'b1111;
      if (key9 && !o_row[2]) i_col[1] = 1'b0;
      if (ghost && !o_row[0]) i_col[1:0] = 2'b00;
      if (key0 && !o_row[0]) i_col[0] = 1'b0;
   end

   // Count every valid pulse seen
   always @(posedge clk) if (o_valid === 1'b1) n_valid++;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Edge numbers in comments count posedges since the first reset release
   initial begin
      rst = 1'b1;
      step(3);
      check("rst_row", o_row, 4'b1110);
      check("rst_key", o_key, 4'h0);
      check("rst_valid", {3'b0, o_valid}, 4'h0);
      check("rst_pressed", {3'b0, o_pressed}, 4'h0);
      rst = 1'b0;

      // Idle scan: row advances every 16 cycles
      step(15);  check("scan_row_e15", o_row, 4'b1110);
      step(1);   check("scan_row_e16", o_row, 4'b1101);
      step(16);  check("scan_row_e32", o_row, 4'b1011);
      step(16);  check("scan_row_e48", o_row, 4'b0111);
      step(16);  check("scan_row_e64", o_row, 4'b1110);

      // Press key 9: detected at tick 112, accepted at tick 160
      key9 = 1'b1;
      step(95);  check("press_pre_valid", {3'b0, o_valid}, 4'h0);
      step(1);
      check("press_valid", {3'b0, o_valid}, 4'h1);
      check("press_key", o_key, 4'h9);
      check("press_pressed", {3'b0, o_pressed}, 4'h1);
      check("press_row", o_row, 4'b1011);
      step(1);   check("press_valid_1cyc", {3'b0, o_valid}, 4'h0);
      step(64);
      check("held_row", o_row, 4'b1011);
      check("held_nvalid", 4'(n_valid), 4'd1);
      check("held_pressed", {3'b0, o_pressed}, 4'h1);

      // Release at 225: idle ticks 240..288, pressed falls at 288
      key9 = 1'b0;
      step(62);  check("rel_pressed_e287", {3'b0, o_pressed}, 4'h1);
      step(1);
      check("rel_pressed_e288", {3'b0, o_pressed}, 4'h0);
      check("rel_row_e288", o_row, 4'b0111);

      // Bounce: detected at 352, agrees at 368, gone by 384
      key9 = 1'b1;
      step(82);
      key9 = 1'b0;
      step(13);  check("bounce_row_frozen", o_row, 4'b1011);
      step(1);
      check("bounce_row_resume", o_row, 4'b0111);
      check("bounce_nvalid", 4'(n_valid), 4'd1);
      check("bounce_key", o_key, 4'h9);
      check("bounce_pressed", {3'b0, o_pressed}, 4'h0);

      // Ghost on row 0 (driven 400..415): row must keep advancing at 416
      ghost = 1'b1;
      step(32);
      check("ghost_row", o_row, 4'b1101);
      check("ghost_nvalid", 4'(n_valid), 4'd1);
      check("ghost_pressed", {3'b0, o_pressed}, 4'h0);
      ghost = 1'b0;

      // Release with glitch: accept at 496, release, re-press for tick 528, final release
      key9 = 1'b1;
      step(80);
      check("glitch_valid", {3'b0, o_valid}, 4'h1);
      check("glitch_key", o_key, 4'h9);
      step(1);   key9 = 1'b0;
      step(16);  check("glitch_pressed_rel1", {3'b0, o_pressed}, 4'h1);
      key9 = 1'b1;
      step(16);
      check("glitch_pressed_repress", {3'b0, o_pressed}, 4'h1);
      check("glitch_row", o_row, 4'b1011);
      key9 = 1'b0;
      step(62);  check("glitch_pressed_e591", {3'b0, o_pressed}, 4'h1);
      step(1);
      check("glitch_pressed_e592", {3'b0, o_pressed}, 4'h0);
      check("glitch_row_resume", o_row, 4'b0111);
      check("glitch_nvalid", 4'(n_valid), 4'd2);

      // Key 0 detected at 624, second sample at 640, reset at 641
      key0 = 1'b1;
      step(49);
      rst = 1'b1;
      #1;
      check("mrst_row", o_row, 4'b1110);
      check("mrst_key", o_key, 4'h0);
      check("mrst_valid", {3'b0, o_valid}, 4'h0);
      check("mrst_pressed", {3'b0, o_pressed}, 4'h0);
      step(2);
      rst = 1'b0;
      // Fresh debounce from scratch: detect at 16, accept at 64
      step(63);
      check("mrst_no_early_valid", {3'b0, o_valid}, 4'h0);
      check("mrst_nvalid_pre", 4'(n_valid), 4'd2);
      step(1);
      check("mrst_valid", {3'b0, o_valid}, 4'h1);
      check("mrst_key0", o_key, 4'h0);
      check("mrst_pressed1", {3'b0, o_pressed}, 4'h1);
      step(2);
      check("mrst_nvalid_post", 4'(n_valid), 4'd3);
      key0 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
